dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
Data-memory side of the decode controller's store/load control. It consumes the 4-bit byte-lane write mask and func3 produced in ID, and runs a multi-cycle req/gnt/rvalid handshake with the data SRAM/bus. It aligns store data and strobes to byte lanes, and extracts and sign-extends load data. It stalls the pipeline until the access completes, and sits between EX/MEM and the data memory port.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before the access is aborted with bus_err
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  pipeline presents a memory instruction; held stable while stall=1
req_we_mask  input  4  decode write mask: 0001 sb, 0011 sh, 1111 sw, 0000 load
req_func3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
req_addr  input  32  effective byte address
req_wdata  input  32  rs2 value, LSB-justified
stall  output  1  freeze pipeline (combinational)
rsp_valid  output  1  1-cycle pulse: access done, rsp_rdata valid for loads
rsp_rdata  output  32  aligned, extended load result; 0 for stores
bus_err  output  1  qualifies rsp_valid: timeout occurred
misalign  output  1  1-cycle pulse: misaligned request rejected
mem_req  output  1  memory request, held until mem_gnt
mem_we  output  1  1 = write
mem_addr  output  32  word address, {req_addr[31:2],2'b00}
mem_wstrb  output  4  byte-lane strobes
mem_wdata  output  32  lane-shifted write data
mem_gnt  input  1  memory accepts request this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read word

Behaviour:
- Reset, async on rst_n=0: state IDLE; all registered outputs 0 (mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, rsp_valid, rsp_rdata, bus_err, misalign); counter 0. Reset mid-access drops mem_req immediately and discards any pending response.
- Access kind: store iff req_we_mask!=0, else load. Undefined load func3 (011,110,111) is treated as lw.
- Misalignment rule: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Misaligned request in IDLE: no memory access; misalign=1 next cycle for exactly 1 cycle; stall=0; rsp_valid stays 0; state stays IDLE.
- IDLE, aligned req_valid: latch addr[1:0], func3 and store/load; drive mem_* registers; go to REQ. mem_req=1 from the next cycle.
- Store lanes: mem_wstrb = req_we_mask << addr[1:0]; mem_wdata = req_wdata << (8*addr[1:0]); mem_we=1.
- Load lanes: mem_wstrb=0, mem_we=0.
- REQ: mem_req held, mem_* stable until mem_gnt=1. On mem_gnt, mem_req drops next cycle.
  - Store: go to RESP.
  - Load with mem_rvalid in the same cycle: capture data, go to RESP.
  - Load otherwise: go to WAIT.
  - mem_rvalid without mem_gnt is ignored.
- WAIT: on mem_rvalid, capture data and go to RESP.
- Load extraction: shift mem_rdata right by 8*addr_lat[1:0].
  - lb/lh: sign-extend from bit 7/15.
  - lbu/lhu: zero-extend.
  - lw: pass through.
- RESP: one cycle. rsp_valid=1 and rsp_rdata valid; then return to IDLE. The request still present in the RESP cycle is never re-accepted; the next request is sampled in IDLE.
- stall = (IDLE & req_valid & aligned) | REQ | WAIT. stall=0 in RESP so the instruction retires that cycle.
- Timeout: counter clears in IDLE and increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES:
  - drop mem_req and go to RESP;
  - bus_err=1 with rsp_valid, rsp_rdata=0;
  - a late mem_rvalid/mem_gnt in IDLE is ignored.
- Minimum latency: store with gnt at first REQ cycle gives rsp_valid 2 cycles after acceptance. Load with same-cycle gnt+rvalid gives 2 cycles; each extra wait cycle adds 1.

Test Plan:
- sw addr 0x100, wdata 0xDEADBEEF, gnt at first REQ cycle -> mem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF, we=1; rsp_valid 2 cycles after acceptance; stall high 2 cycles.
- sb addr 0x103, wdata 0x000000A5 -> wstrb 1000, wdata 0xA5000000, mem_addr 0x100.
- lb addr 0x102, rdata 0x12F45678, rvalid 3 cycles after gnt -> rsp_rdata 0xFFFFFFF4. Same with lbu -> 0x000000F4. lhu addr 0x102 -> 0x000012F4.
- lw addr 0x201 -> misalign pulse 1 cycle, mem_req never asserted, stall=0, rsp_valid=0. sh addr 0x202 -> accepted normally with wstrb 1100.
- Load with mem_gnt never asserted, TIMEOUT_CYCLES=4 -> mem_req drops after 4 REQ cycles; rsp_valid=1, bus_err=1, rsp_rdata=0; a later stray rvalid is ignored.
- rst_n low while in WAIT -> mem_req=0 and all outputs 0 immediately. After release, a new lw completes normally with no spurious rsp_valid.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: aligns stores to byte lanes, runs the req/gnt/rvalid
// handshake with timeout, and extracts/extends load data.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [3:0]  req_we_mask,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        bus_err,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       f3_q, f3_d;
    logic             store_q, store_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             bus_err_q, bus_err_d;
    logic             misalign_q, misalign_d;

    logic        is_store;
    logic        acc_half;
    logic        acc_word;
    logic        misaligned;
    logic [31:0] lane_data;
    logic [31:0] load_data;
    logic        timeout_hit;

    assign is_store    = |req_we_mask;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Access size comes from the write mask for stores and from func3 for loads.
    always_comb begin
        if (is_store) begin
            acc_half = (req_we_mask == 4'b0011);
            acc_word = (req_we_mask != 4'b0001) && (req_we_mask != 4'b0011);
        end else begin
            acc_half = (req_func3[1:0] == 2'b01);
            acc_word = req_func3[1];
        end
        misaligned = (acc_half & req_addr[0]) | (acc_word & (|req_addr[1:0]));
    end

    always_comb begin
        lane_data = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b001:  load_data = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b100:  load_data = {24'h0, lane_data[7:0]};
            3'b101:  load_data = {16'h0, lane_data[15:0]};
            default: load_data = lane_data;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        f3_d        = f3_q;
        store_d     = store_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        bus_err_d   = 1'b0;
        misalign_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        off_d       = req_addr[1:0];
                        f3_d        = req_func3;
                        store_d     = is_store;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wstrb_d = is_store ? 4'(req_we_mask << req_addr[1:0]) : 4'b0000;
                        mem_wdata_d = is_store ? (req_wdata << {req_addr[1:0], 3'b000}) : '0;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completing handshake wins over a timeout landing in the same cycle.
                if (mem_gnt && (store_q || mem_rvalid)) begin
                    mem_req_d   = 1'b0;
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = store_q ? '0 : load_data;
                end else if (timeout_hit) begin
                    mem_req_d   = 1'b0;
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    bus_err_d   = 1'b1;
                end else if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rvalid) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data;
                end else if (timeout_hit) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    bus_err_d   = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            off_q       <= '0;
            f3_q        <= '0;
            store_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            bus_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            store_q     <= store_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            bus_err_q   <= bus_err_d;
            misalign_q  <= misalign_d;
        end
    end

    assign stall     = ((state_q == S_IDLE) && req_valid && !misaligned) ||
                       (state_q == S_REQ) || (state_q == S_WAIT);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_err   = bus_err_q;
    assign misalign  = misalign_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: transaction-level model with a
// per-cycle compare process, directed literal cases and randomized accesses.
module tb_dmem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [3:0]  req_we_mask;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        bus_err;
    logic        misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    dmem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we_mask(req_we_mask), .req_func3(req_func3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bus_err(bus_err), .misalign(misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          chk_en = 1'b0;
    logic        exp_stall, exp_mem_req, exp_rsp_valid, exp_bus_err, exp_misalign, exp_we;
    logic [31:0] exp_rsp_rdata, exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;

    logic [31:0] cap_addr, cap_wdata, cap_rdata;
    logic [3:0]  cap_wstrb;
    logic        cap_we, cap_err;
    int          req_cycles = 0, stall_cycles = 0, rsp_cnt = 0, mis_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Load result from the word, byte offset and func3, in plain arithmetic.
    function automatic logic [31:0] ld_model(input logic [31:0] w, input int off,
                                             input logic [2:0] f3);
        int unsigned s, b, h;
        s = w >> (8 * off);
        b = s % 256;
        h = s % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return s;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mem_req) begin
            req_cycles++;
            cap_addr  = mem_addr;
            cap_we    = mem_we;
            cap_wstrb = mem_wstrb;
            cap_wdata = mem_wdata;
        end
        if (stall) stall_cycles++;
        if (misalign) mis_cnt++;
        if (rsp_valid) begin
            rsp_cnt++;
            cap_rdata = rsp_rdata;
            cap_err   = bus_err;
        end
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("mem_req", 32'(mem_req), 32'(exp_mem_req));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            chk("bus_err", 32'(bus_err), 32'(exp_bus_err));
            chk("misalign", 32'(misalign), 32'(exp_misalign));
            if (exp_mem_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (exp_rsp_valid) chk("rsp_rdata", rsp_rdata, exp_rsp_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_stall = 0; exp_mem_req = 0; exp_rsp_valid = 0; exp_bus_err = 0;
        exp_misalign = 0; exp_rsp_rdata = 0;
    endtask

    // g: REQ cycle (1-based) in which gnt is given, 0 = never; d: rvalid delay after gnt.
    task automatic do_access(input logic [3:0] mask, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int g, input int d, input logic [31:0] rd);
        int off, sz, c, e, m;
        bit st, mis, err;
        off = int'(addr % 4);
        st  = (mask != 0);
        m   = int'(mask);
        if (st) sz = (mask == 4'b0001) ? 1 : (mask == 4'b0011) ? 2 : 4;
        else    sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        mis = (addr % sz) != 0;

        req_valid = 1; req_we_mask = mask; req_func3 = f3; req_addr = addr; req_wdata = wd;
        mem_gnt = 0; mem_rvalid = 0;
        set_idle_exp();
        exp_stall = !mis;
        exp_addr  = addr - off;
        exp_we    = st;
        exp_wstrb = st ? 4'((m << off) % 16) : 4'h0;
        exp_wdata = st ? (wd << (8 * off)) : 32'h0;

        if (mis) begin
            step();
            req_valid = 0;
            exp_stall = 0; exp_misalign = 1;
            step();
            return;
        end

        if (g == 0) c = 1000;
        else        c = st ? g : g + d;
        err = (c > TO);
        e   = err ? TO : c;

        for (int k = 1; k <= e; k++) begin
            step();
            mem_gnt = (k == g);
            if (g == 0 || k < g) begin
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
            end else begin
                mem_rvalid = !st && (k == g + d);
                mem_rdata  = rd;
            end
            exp_stall   = 1;
            exp_mem_req = (g == 0) || (k <= g);
        end

        step();
        mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        exp_stall = 0; exp_mem_req = 0; exp_rsp_valid = 1; exp_bus_err = err;
        exp_rsp_rdata = (err || st) ? 32'h0 : ld_model(rd, off, f3);

        step();
        req_valid = 0;
        mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
        set_idle_exp();

        step();
        mem_gnt = 0; mem_rvalid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, s0, q0, m0;
        rst_n = 0; req_valid = 0; req_we_mask = 0; req_func3 = 0; req_addr = 0;
        req_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        set_idle_exp();
        #3;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_outputs", {mem_addr | mem_wdata | rsp_rdata}, 0);
        chk("rst_flags", {27'h0, mem_we, bus_err, misalign, mem_wstrb != 0, stall}, 0);
        step();
        rst_n = 1;
        chk_en = 1;
        step();

        s0 = stall_cycles;
        do_access(4'b1111, 3'b010, 32'h100, 32'hDEADBEEF, 1, 0, 0);
        chk("sw_addr", cap_addr, 32'h100);
        chk("sw_we", 32'(cap_we), 1);
        chk("sw_wstrb", 32'(cap_wstrb), 32'hF);
        chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
        chk("sw_stall_cycles", stall_cycles - s0, 2);

        do_access(4'b0001, 3'b000, 32'h103, 32'h000000A5, 2, 0, 0);
        chk("sb_wstrb", 32'(cap_wstrb), 32'h8);
        chk("sb_wdata", cap_wdata, 32'hA5000000);
        chk("sb_addr", cap_addr, 32'h100);

        do_access(4'b0000, 3'b000, 32'h102, 0, 1, 3, 32'h12F45678);
        chk("lb_rdata", cap_rdata, 32'hFFFFFFF4);
        do_access(4'b0000, 3'b100, 32'h102, 0, 1, 3, 32'h12F45678);
        chk("lbu_rdata", cap_rdata, 32'h000000F4);
        do_access(4'b0000, 3'b101, 32'h102, 0, 2, 0, 32'h12F45678);
        chk("lhu_rdata", cap_rdata, 32'h000012F4);

        r0 = rsp_cnt; q0 = req_cycles; m0 = mis_cnt;
        do_access(4'b0000, 3'b010, 32'h201, 0, 1, 0, 0);
        chk("mis_pulses", mis_cnt - m0, 1);
        chk("mis_no_req", req_cycles - q0, 0);
        chk("mis_no_rsp", rsp_cnt - r0, 0);

        do_access(4'b0011, 3'b001, 32'h202, 32'h0000BEEF, 1, 0, 0);
        chk("sh_wstrb", 32'(cap_wstrb), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hBEEF0000);

        r0 = rsp_cnt; q0 = req_cycles;
        do_access(4'b0000, 3'b010, 32'h400, 0, 0, 0, 0);
        chk("to_req_cycles", req_cycles - q0, TO);
        chk("to_bus_err", 32'(cap_err), 1);
        chk("to_rdata", cap_rdata, 0);
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_gnt = 0; mem_rvalid = 0;
        step();
        chk("to_single_rsp", rsp_cnt - r0, 1);
        chk("to_no_new_req", req_cycles - q0, TO);

        // Reset while a load sits in WAIT.
        chk_en = 0;
        req_valid = 1; req_we_mask = 0; req_func3 = 3'b010; req_addr = 32'h300;
        step();
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        chk("wait_stall", 32'(stall), 1);
        #2;
        rst_n = 0; req_valid = 0;
        #1;
        chk("rst_wait_mem_req", 32'(mem_req), 0);
        chk("rst_wait_addr", mem_addr, 0);
        chk("rst_wait_flags", {28'h0, rsp_valid, bus_err, misalign, stall}, 0);
        step();
        mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
        step();
        mem_rvalid = 0; rst_n = 1;
        set_idle_exp();
        r0 = rsp_cnt;
        chk_en = 1;
        step();
        step();
        chk("rst_no_spurious_rsp", rsp_cnt - r0, 0);
        do_access(4'b0000, 3'b010, 32'h500, 0, 1, 1, 32'h89ABCDEF);
        chk("post_rst_lw", cap_rdata, 32'h89ABCDEF);
        chk("post_rst_rsp_cnt", rsp_cnt - r0, 1);

        for (int i = 0; i < 80; i++) begin
            logic [3:0]  mk;
            logic [2:0]  f;
            int          sel;
            sel = $urandom_range(0, 5);
            mk  = (sel == 0) ? 4'b0001 : (sel == 1) ? 4'b0011 : (sel == 2) ? 4'b1111 : 4'b0000;
            f   = 3'($urandom_range(0, 7));
            do_access(mk, f, $urandom, $urandom, $urandom_range(0, 5),
                      $urandom_range(0, 4), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
